// File: rtl/vga_timing_rx.sv
// vga_timing_rx
// Recovers pixel/line counters from an active-low hsync/vsync pair. The block
// measures the line length, acquires the frame height, declares lock, and
// then polices every sync edge against the recovered counters.
//
// Optional feature: define BLANK_CHECK_EN to also compare the source blank
// against the internally derived blank while locked.
//
// Ports:
//   i_vclock       pixel clock (all logic on rising edge)
//   i_rst_n        asynchronous active-low reset
//   i_hsync_in     horizontal sync, active low
//   i_vsync_in     vertical sync, active low
//   i_blank_in     source blank (only used with BLANK_CHECK_EN)
//   o_hcount       recovered pixel number
//   o_vcount       recovered line number
//   o_h_total      measured pixels per line
//   o_v_total      measured lines per frame
//   o_locked       recovered counters valid
//   o_active       locked and inside the active area
//   o_frame_start  one-cycle pulse when counters wrap to (0,0) while locked
//   o_err          one-cycle pulse on any timing violation
//   o_err_cnt      saturating violation count
module vga_timing_rx #(
    parameter int unsigned H_SYNC_POS = 1048,
    parameter int unsigned V_SYNC_POS = 777,
    parameter int unsigned H_ACTIVE   = 1024,
    parameter int unsigned V_ACTIVE   = 768,
    parameter int unsigned LOCK_LINES = 4
) (
    input  logic        i_vclock,
    input  logic        i_rst_n,
    input  logic        i_hsync_in,
    input  logic        i_vsync_in,
    input  logic        i_blank_in,
    output logic [10:0] o_hcount,
    output logic [9:0]  o_vcount,
    output logic [10:0] o_h_total,
    output logic [9:0]  o_v_total,
    output logic        o_locked,
    output logic        o_active,
    output logic        o_frame_start,
    output logic        o_err,
    output logic [7:0]  o_err_cnt
);

    typedef enum logic [1:0] {StSearch, StHAcq, StVAcq, StLocked} state_e;

    localparam logic [10:0] PcntMax   = 11'h7ff;
    localparam logic [10:0] HSyncPos  = 11'(H_SYNC_POS);
    localparam logic [9:0]  VSyncPos  = 10'(V_SYNC_POS);
    localparam logic [10:0] HActive   = 11'(H_ACTIVE);
    localparam logic [9:0]  VActive   = 10'(V_ACTIVE);
    localparam logic [7:0]  MatchLock = 8'(LOCK_LINES - 1);

    state_e      r_state;
    logic        r_hs_q;
    logic        r_vs_q;
    logic [10:0] r_pcnt;
    logic [10:0] r_period;
    logic [7:0]  r_match;
    logic [10:0] r_lcnt;
    logic        r_vseen;
    logic [10:0] r_hcount;
    logic [9:0]  r_vcount;
    logic [10:0] r_h_total;
    logic [9:0]  r_v_total;
    logic        r_locked;
    logic        r_active;
    logic        r_frame_start;
    logic        r_err;
    logic [7:0]  r_err_cnt;

    logic        w_hfall;
    logic        w_vfall;
    logic        w_timeout;
    logic        w_hwrap;
    logic        w_vwrap;
    logic [10:0] w_hcount_run;
    logic [10:0] w_hcount_acq;
    logic [9:0]  w_vcount_run;
    logic [10:0] w_lcnt_next;
    logic [7:0]  w_match_inc;
    logic        w_lcnt_ok;
    logic        w_blank_viol;
    logic        w_lock_viol;
    logic        w_viol;
    logic        w_active_run;

    assign w_hfall = r_hs_q & ~i_hsync_in;
    assign w_vfall = r_vs_q & ~i_vsync_in;

    // A stuck hsync saturates the period counter; treat that as lost timing.
    assign w_timeout = (r_pcnt == PcntMax) && (r_state != StSearch);

    // Free-running counter advance, used in V_ACQ and LOCKED.
    assign w_hwrap      = (r_hcount == r_h_total - 11'd1);
    assign w_vwrap      = (r_vcount == r_v_total - 10'd1);
    assign w_hcount_run = w_hwrap ? 11'd0 : r_hcount + 11'd1;
    assign w_hcount_acq = w_hfall ? HSyncPos : w_hcount_run;
    assign w_vcount_run = !w_hwrap ? r_vcount : (w_vwrap ? 10'd0 : r_vcount + 10'd1);

    // Line count including a wrap on this same edge, so a vfall aligned with
    // the line start and one placed mid-line both measure the true height.
    assign w_lcnt_next = (w_hwrap && (r_lcnt != PcntMax)) ? r_lcnt + 11'd1 : r_lcnt;
    assign w_lcnt_ok   = (w_lcnt_next >= 11'd2) && (w_lcnt_next <= 11'd1023);
    assign w_match_inc = r_match + 8'd1;

`ifdef BLANK_CHECK_EN
    logic r_blank_q;

    // Registered blank describes the same source pixel as r_hcount/r_vcount.
    always_ff @(posedge i_vclock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blank_q <= 1'b1;
        end else begin
            r_blank_q <= i_blank_in;
        end
    end

    assign w_blank_viol = r_blank_q != !((r_hcount < HActive) && (r_vcount < VActive));
`else
    logic w_unused_blank;

    assign w_unused_blank = i_blank_in;
    assign w_blank_viol   = 1'b0;
`endif

    assign w_lock_viol = (w_hfall && ((w_hcount_run != HSyncPos) || (r_pcnt != r_h_total)))
                      || (w_vfall && ((w_vcount_run != VSyncPos) || (w_hcount_run != 11'd0)))
                      || w_blank_viol;

    assign w_viol = w_timeout
                 || ((r_state == StLocked) && w_lock_viol)
                 || ((r_state == StVAcq) && w_vfall && r_vseen && !w_lcnt_ok);

    assign w_active_run = (w_hcount_run < HActive) && (w_vcount_run < VActive);

    always_ff @(posedge i_vclock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StSearch;
            r_hs_q        <= 1'b1;
            r_vs_q        <= 1'b1;
            r_pcnt        <= 11'd0;
            r_period      <= 11'd0;
            r_match       <= 8'd0;
            r_lcnt        <= 11'd0;
            r_vseen       <= 1'b0;
            r_hcount      <= 11'd0;
            r_vcount      <= 10'd0;
            r_h_total     <= 11'd0;
            r_v_total     <= 10'd0;
            r_locked      <= 1'b0;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
            r_err         <= 1'b0;
            r_err_cnt     <= 8'd0;
        end else begin
            r_hs_q <= i_hsync_in;
            r_vs_q <= i_vsync_in;

            if (w_hfall) begin
                r_pcnt <= 11'd1;
            end else if (r_pcnt != PcntMax) begin
                r_pcnt <= r_pcnt + 11'd1;
            end

            r_err         <= 1'b0;
            r_frame_start <= 1'b0;
            r_active      <= 1'b0;

            if (w_viol) begin
                r_err    <= 1'b1;
                r_locked <= 1'b0;
                r_state  <= StSearch;
                if (r_err_cnt != 8'hff) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else begin
                case (r_state)
                    StSearch: begin
                        // Period 0 never matches, so the partial line after
                        // reset or a violation is never counted.
                        if (w_hfall) begin
                            r_state  <= StHAcq;
                            r_match  <= 8'd0;
                            r_period <= 11'd0;
                        end
                    end
                    StHAcq: begin
                        if (w_hfall) begin
                            if (r_pcnt == r_period) begin
                                if (w_match_inc == MatchLock) begin
                                    r_h_total <= r_period;
                                    r_hcount  <= HSyncPos;
                                    r_vseen   <= 1'b0;
                                    r_lcnt    <= 11'd0;
                                    r_state   <= StVAcq;
                                end else begin
                                    r_match <= w_match_inc;
                                end
                            end else begin
                                r_period <= r_pcnt;
                                r_match  <= 8'd0;
                            end
                        end
                    end
                    StVAcq: begin
                        r_hcount <= w_hcount_acq;
                        r_vcount <= w_vcount_run;
                        r_lcnt   <= w_lcnt_next;
                        if (w_vfall) begin
                            r_vcount <= VSyncPos;
                            if (!r_vseen) begin
                                r_vseen <= 1'b1;
                                r_lcnt  <= 11'd0;
                            end else begin
                                r_v_total <= w_lcnt_next[9:0];
                                r_locked  <= 1'b1;
                                r_active  <= (w_hcount_acq < HActive) && (VSyncPos < VActive);
                                r_state   <= StLocked;
                            end
                        end
                    end
                    StLocked: begin
                        r_hcount      <= w_hcount_run;
                        r_vcount      <= w_vcount_run;
                        r_active      <= w_active_run;
                        r_frame_start <= (w_hcount_run == 11'd0) && (w_vcount_run == 10'd0);
                    end
                    default: r_state <= StSearch;
                endcase
            end
        end
    end

    assign o_hcount      = r_hcount;
    assign o_vcount      = r_vcount;
    assign o_h_total     = r_h_total;
    assign o_v_total     = r_v_total;
    assign o_locked      = r_locked;
    assign o_active      = r_active;
    assign o_frame_start = r_frame_start;
    assign o_err         = r_err;
    assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx using a reduced 32x18 raster (16x12 active) so
// several frames fit in a short run. A source model generates sync/blank;
// expected recovered counters are queued when a pixel is driven and popped
// one cycle later when the receiver shows it.
module tb_vga_timing_rx;

    localparam int HT    = 32;
    localparam int VT    = 18;
    localparam int HA    = 16;
    localparam int VA    = 12;
    localparam int HSP   = 20;
    localparam int VSP   = 14;
    localparam int HSW   = 4;
    localparam int VSW   = 3;
    localparam int FRAME = HT * VT;

    typedef struct {
        int h;
        int v;
        bit act;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic [10:0] o_hcount;
    logic [9:0]  o_vcount;
    logic [10:0] o_h_total;
    logic [9:0]  o_v_total;
    logic        o_locked;
    logic        o_active;
    logic        o_frame_start;
    logic        o_err;
    logic [7:0]  o_err_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    int   err_seen = 0;
    int   act_seen = 0;
    int   fs_seen  = 0;
    int   s_h      = 0;
    int   s_v      = 0;
    int   ev_v     = 0;
    bit   dly_on   = 0;
    bit   vs_mute  = 0;
    bit   hs_hold  = 0;
    bit   blank_force = 0;
    bit   sb_en    = 0;
    exp_t sb[$];

    vga_timing_rx #(
        .H_SYNC_POS (HSP),
        .V_SYNC_POS (VSP),
        .H_ACTIVE   (HA),
        .V_ACTIVE   (VA),
        .LOCK_LINES (4)
    ) u_dut (
        .i_vclock      (clk),
        .i_rst_n       (rst_n),
        .i_hsync_in    (hsync),
        .i_vsync_in    (vsync),
        .i_blank_in    (blank),
        .o_hcount      (o_hcount),
        .o_vcount      (o_vcount),
        .o_h_total     (o_h_total),
        .o_v_total     (o_v_total),
        .o_locked      (o_locked),
        .o_active      (o_active),
        .o_frame_start (o_frame_start),
        .o_err         (o_err),
        .o_err_cnt     (o_err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.h   = s_h;
        e.v   = s_v;
        e.act = (s_h < HA) && (s_v < VA);
        sb.push_back(e);
    endtask

    // Drive the sync/blank for source pixel (s_h, s_v).
    task automatic drive_src();
        int d;
        d     = (dly_on && s_v == ev_v) ? 3 : 0;
        hsync = hs_hold ? 1'b1 : !((s_h >= HSP + d) && (s_h < HSP + HSW + d));
        vsync = vs_mute ? 1'b1 : !((s_v >= VSP) && (s_v < VSP + VSW));
        blank = !((s_h < HA) && (s_v < VA));
        if (blank_force && s_v == ev_v && s_h == 18) blank = 1'b0;
        if (sb_en && (s_h % 4 == 0)) push_exp();
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (o_err) err_seen++;
        if (o_active) act_seen++;
        if (o_frame_start) fs_seen++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("hcount", int'(o_hcount), e.h);
            check("vcount", int'(o_vcount), e.v);
            check("active", int'(o_active), int'(e.act));
        end
        s_h++;
        if (s_h == HT) begin
            s_h = 0;
            s_v++;
            if (s_v == VT) s_v = 0;
        end
        drive_src();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic goto(input int h, input int v);
        for (int n = 0; n < FRAME + 1; n++) begin
            if (s_h == h && s_v == v) break;
            step();
        end
    endtask

    task automatic wait_lock(input string tag, input int bound);
        int n;
        n = 0;
        while (!o_locked && n < bound) begin
            step();
            n++;
        end
        check(tag, int'(o_locked), 1);
    endtask

    initial begin
        // Reset with the source parked mid-line.
        rst_n = 1'b0;
        s_h   = 5;
        s_v   = 3;
        drive_src();
        repeat (3) @(posedge clk);
        #1;
        check("rst_hcount", int'(o_hcount), 0);
        check("rst_vcount", int'(o_vcount), 0);
        check("rst_h_total", int'(o_h_total), 0);
        check("rst_v_total", int'(o_v_total), 0);
        check("rst_locked", int'(o_locked), 0);
        check("rst_active", int'(o_active), 0);
        check("rst_frame_start", int'(o_frame_start), 0);
        check("rst_err", int'(o_err), 0);
        check("rst_err_cnt", int'(o_err_cnt), 0);
        rst_n = 1'b1;

        // Acquisition from a mid-line start.
        wait_lock("initial_lock", 3 * FRAME + 100);
        check("h_total", int'(o_h_total), HT);
        check("v_total", int'(o_v_total), VT);
        check("acq_err_cnt", int'(o_err_cnt), 0);

        // One full locked frame through the scoreboard.
        goto(0, 0);
        err_seen = 0;
        act_seen = 0;
        fs_seen  = 0;
        sb_en    = 1;
        push_exp();
        run(FRAME);
        sb_en = 0;
        check("active_per_frame", act_seen, HA * VA);
        check("frame_start_per_frame", fs_seen, 1);
        check("nominal_err", err_seen, 0);
        run(1);

        // One hsync fall late by 3 cycles.
        goto(0, 5);
        ev_v     = 5;
        dly_on   = 1;
        err_seen = 0;
        run(HT);
        dly_on = 0;
        run(4);
        check("hdelay_err_pulses", err_seen, 1);
        check("hdelay_err_cnt", int'(o_err_cnt), 1);
        check("hdelay_unlocked", int'(o_locked), 0);
        wait_lock("hdelay_relock", 3 * FRAME + 100);
        check("relock_h_total", int'(o_h_total), HT);
        check("relock_v_total", int'(o_v_total), VT);

        // Vsync missing for one frame, then back on time.
        goto(0, 0);
        err_seen = 0;
        vs_mute  = 1;
        drive_src();
        run(FRAME);
        vs_mute = 0;
        sb_en   = 1;
        push_exp();
        run(FRAME);
        sb_en = 0;
        run(1);
        check("vmute_err", err_seen, 0);
        check("vmute_locked", int'(o_locked), 1);
        check("vmute_err_cnt", int'(o_err_cnt), 1);

        // Source blank dropped low inside horizontal blanking.
        goto(0, 2);
        ev_v        = 2;
        blank_force = 1;
        err_seen    = 0;
        run(HT);
        blank_force = 0;
        run(4);
`ifdef BLANK_CHECK_EN
        check("blank_err", err_seen, 1);
        check("blank_locked", int'(o_locked), 0);
        check("blank_err_cnt", int'(o_err_cnt), 2);
`else
        check("blank_err", err_seen, 0);
        check("blank_locked", int'(o_locked), 1);
        check("blank_err_cnt", int'(o_err_cnt), 1);
`endif

        // Hsync stuck high while in V_ACQ; vsync muted so lock cannot occur.
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        s_h     = 0;
        s_v     = 0;
        vs_mute = 1;
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        goto(0, 9);
        check("vacq_err_cnt", int'(o_err_cnt), 0);
        check("vacq_unlocked", int'(o_locked), 0);
        hs_hold  = 1;
        err_seen = 0;
        drive_src();
        for (int n = 0; n < 2200; n++) begin
            if (err_seen > 0) break;
            step();
        end
        check("timeout_err", err_seen, 1);
        run(10);
        check("timeout_single_pulse", err_seen, 1);
        check("timeout_err_cnt", int'(o_err_cnt), 1);
        check("timeout_unlocked", int'(o_locked), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_rx.md
# vga_timing_rx

Receive-side video timing recovery block: watches the active-low hsync/vsync pair (and optionally blank) produced by the team's 1024x768 @ 60 Hz XVGA timing generator and rebuilds the pixel/line counters from the sync edges alone. It measures line length and frame height, declares lock after a consistent frame, and flags timing violations. It sits at the far end of a video link, or in a loopback self-check next to the generator, and feeds downstream pixel consumers the recovered hcount/vcount/active.

## Interface
- H_SYNC_POS, 1048: hcount value of the first pixel with hsync low
- V_SYNC_POS, 777: vcount value of the first line with vsync low
- H_ACTIVE, 1024: active pixels per line
- V_ACTIVE, 768: active lines per frame
- LOCK_LINES, 4: consecutive equal line periods required before frame acquisition
- vclock  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- hsync_in  in  1  horizontal sync, active low, synchronous to vclock
- vsync_in  in  1  vertical sync, active low, synchronous to vclock
- blank_in  in  1  blanking from source; used only with BLANK_CHECK_EN
- hcount  out  11  recovered pixel number
- vcount  out  10  recovered line number
- h_total  out  11  measured pixels per line (1344 nominal)
- v_total  out  10  measured lines per frame (806 nominal)
- locked  out  1  recovered counters valid
- active  out  1  locked & hcount<H_ACTIVE & vcount<V_ACTIVE
- frame_start  out  1  one-cycle pulse when recovered counters wrap to (0,0) while locked
- err  out  1  one-cycle pulse on any timing violation
- err_cnt  out  8  saturating violation count

## Operation
- Inputs registered once (hs_q, vs_q). Fall events: hfall = hs_q & ~hsync_in; vfall = vs_q & ~vsync_in.
- Period counter pcnt (11 bit, saturating at 2047) counts cycles since last hfall; reset to 1 on hfall.
- States: SEARCH, H_ACQ, V_ACQ, LOCKED.
- SEARCH: first hfall -> H_ACQ, match count=0.
- H_ACQ: each hfall compares pcnt with stored period; equal increments match, else stores new period and match=0. match reaching LOCK_LINES-1 -> h_total<=period, -> V_ACQ.
- V_ACQ: hcount free-runs mod h_total, loaded with H_SYNC_POS on hfall. First vfall loads vcount<=V_SYNC_POS and starts line counter; line counter increments on each hcount wrap. Second vfall: if line count in [2,1023] -> v_total<=count, locked<=1, -> LOCKED; else err, -> SEARCH.
- LOCKED: hcount wraps h_total-1 -> 0 and increments vcount; vcount wraps v_total-1 -> 0. Violations: hfall while next hcount != H_SYNC_POS; vfall while next vcount != V_SYNC_POS or next hcount != 0; hfall with pcnt != h_total. Any violation -> err pulse, err_cnt+1 (saturate 255), locked<=0, -> SEARCH.
- Timeout: pcnt reaching 2047 in any state except SEARCH counts as violation.
- vfall and hfall on same edge (nominal case): hfall check applied first, then vfall; single err pulse max per cycle.

## Timing
- Reset: hcount=0, vcount=0, h_total=0, v_total=0, locked=0, active=0, frame_start=0, err=0, err_cnt=0, state SEARCH, hs_q=vs_q=1.
- Latency: recovered hcount/vcount lag the source counters by exactly 1 cycle (source hcount=1048 with first hsync low; receiver shows 1048 one cycle later).
- Lock with nominal source from reset: LOCK_LINES lines + up to 2 frames.
- locked, active, frame_start, err registered; active is 0 whenever locked=0.
- Reset deassertion mid-line: first partial period never counted as a match.

## Configuration
- BLANK_CHECK_EN defined: in LOCKED, blank_in is registered and compared against internal blank (~(hcount<H_ACTIVE & vcount<V_ACTIVE)), both aligned to the same source pixel; mismatch counts as violation.
- Not defined: blank_in unused, no blank logic synthesized; behaviour otherwise identical.

## Test plan
- Nominal 1344x806 source from reset -> locked=1 by end of third vsync fall, h_total=1344, v_total=806, active high for exactly 1024x768 cycles per frame, frame_start once per 1083264 cycles.
- Locked, one hsync fall delayed 3 cycles -> err one cycle, err_cnt=1, locked=0, relock after next valid sequence.
- Locked, vsync held high for a frame -> pcnt unaffected, no err; vfall returns on time -> still locked.
- hsync held high 2047 cycles in V_ACQ -> timeout err, state SEARCH, err_cnt increments.
- 640x480 timing (800x525, H_SYNC_POS=656, V_SYNC_POS=491) -> h_total=800, v_total=525, locked.
- BLANK_CHECK_EN, blank_in forced low at hcount 1030 while locked -> err pulse, locked=0; without macro -> no err.
